// File: rtl/ex_issue_queue.sv
// rtl/ex_issue_queue.sv - in-order issue queue feeding the base integer execution unit
//
// Buffers decoded ALU micro-ops from stage 2. The oldest entry is shown
// combinationally to the EU over a valid/ready handshake. A flush empties
// the queue on a branch mispredict or a trap.
//
// Ports:
//   clk, rst_n               core clock, asynchronous active-low reset
//   flush                    synchronous discard of all entries
//   in_valid/in_ready        stage-2 handshake
//   in_op1/in_op2/in_sel/in_rd   incoming micro-op fields
//   out_valid/out_ready      EU handshake
//   out_op1/out_op2/out_sel/out_rd   head micro-op fields (zero when empty)
//   count                    current occupancy, 0..DEPTH
module ex_issue_queue #(
    parameter int DEPTH = 4,
    parameter int SEL_W = 6,
    parameter int RD_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [63:0]                in_op1,
    input  logic [63:0]                in_op2,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic [RD_W-1:0]            in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_op1,
    output logic [63:0]                out_op2,
    output logic [SEL_W-1:0]           out_sel,
    output logic [RD_W-1:0]            out_rd,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [63:0]      mem_op1 [DEPTH];
    logic [63:0]      mem_op2 [DEPTH];
    logic [SEL_W-1:0] mem_sel [DEPTH];
    logic [RD_W-1:0]  mem_rd  [DEPTH];

    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [CNT_W-1:0] cnt;

    logic enq;
    logic deq;

    // in_ready is a function of the occupancy only, so there is no
    // combinational path from out_ready; a full queue never takes a new
    // entry even when the head leaves in the same cycle.
    assign in_ready  = (cnt != CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign count     = cnt;

    assign enq = in_valid && in_ready;
    assign deq = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            // Flush wins over any handshake in the same cycle.
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (deq) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (enq && !deq) begin
                cnt <= cnt + CNT_W'(1);
            end else if (deq && !enq) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            mem_op1[wptr] <= in_op1;
            mem_op2[wptr] <= in_op2;
            mem_sel[wptr] <= in_sel;
            mem_rd[wptr]  <= in_rd;
        end
    end

    // Show-ahead head read; outputs are forced to zero while empty so stale
    // storage never leaks toward the EU.
    always_comb begin
        out_op1 = '0;
        out_op2 = '0;
        out_sel = '0;
        out_rd  = '0;
        if (out_valid) begin
            out_op1 = mem_op1[rptr];
            out_op2 = mem_op2[rptr];
            out_sel = mem_sel[rptr];
            out_rd  = mem_rd[rptr];
        end
    end

endmodule

// File: tb/tb_ex_issue_queue.sv
// tb/tb_ex_issue_queue.sv - directed self-checking bench for ex_issue_queue
module tb_ex_issue_queue;

    localparam int DEPTH = 4;
    localparam int SEL_W = 6;
    localparam int RD_W  = 5;

    localparam logic [SEL_W-1:0] SEL_ADD   = 6'h01;
    localparam logic [SEL_W-1:0] SEL_AUIPC = 6'h17;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [63:0]             in_op1;
    logic [63:0]             in_op2;
    logic [SEL_W-1:0]        in_sel;
    logic [RD_W-1:0]         in_rd;
    logic                    out_valid;
    logic                    out_ready;
    logic [63:0]             out_op1;
    logic [63:0]             out_op2;
    logic [SEL_W-1:0]        out_sel;
    logic [RD_W-1:0]         out_rd;
    logic [$clog2(DEPTH):0]  count;

    int total = 0;
    int bad   = 0;

    ex_issue_queue #(
        .DEPTH(DEPTH),
        .SEL_W(SEL_W),
        .RD_W (RD_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op1   (in_op1),
        .in_op2   (in_op2),
        .in_sel   (in_sel),
        .in_rd    (in_rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_op1  (out_op1),
        .out_op2  (out_op2),
        .out_sel  (out_sel),
        .out_rd   (out_rd),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [SEL_W-1:0] s, input logic [RD_W-1:0] r);
        in_valid = v;
        in_op1   = a;
        in_op2   = b;
        in_sel   = s;
        in_rd    = r;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'h0, 64'h0, '0, '0);

        // Reset state
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        chk("rel_in_ready", in_ready, 1);

        // Single op, no bypass into the enqueue cycle
        drive(1'b1, 64'h10, 64'h20, SEL_ADD, 5'd5);
        chk("t1_nobypass_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_op1", out_op1, 64'h10);
        chk("t1_op2", out_op2, 64'h20);
        chk("t1_sel", out_sel, SEL_ADD);
        chk("t1_rd", out_rd, 5);
        chk("t1_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_drain_valid", out_valid, 0);
        chk("t1_drain_count", count, 0);

        // Fill to DEPTH, hold a 5th op while full
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(i) << 4, 64'(i) << 8, SEL_ADD, RD_W'(i));
            step();
        end
        drive(1'b1, 64'h50, 64'h500, SEL_ADD, 5'd5);
        chk("t2_full_count", count, 4);
        chk("t2_full_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_hold_count", count, 4);
            chk("t2_hold_head", out_rd, 1);
        end
        out_ready = 1'b1;
        chk("t2_head1", out_rd, 1);
        chk("t2_head1_op1", out_op1, 64'h10);
        step();
        // Full at the edge: only the dequeue happened
        chk("t2_cnt_after_deq", count, 3);
        chk("t2_head2", out_rd, 2);
        step();
        // Fifth op taken while rd 2 left
        in_valid = 1'b0;
        chk("t2_cnt_simul", count, 3);
        chk("t2_head3", out_rd, 3);
        step();
        chk("t2_head4", out_rd, 4);
        step();
        chk("t2_head5", out_rd, 5);
        chk("t2_head5_op2", out_op2, 64'h500);
        step();
        out_ready = 1'b0;
        chk("t2_empty", out_valid, 0);

        // Streaming at count=2
        drive(1'b1, 64'd10, 64'd0, SEL_ADD, 5'd10);
        step();
        drive(1'b1, 64'd11, 64'd0, SEL_ADD, 5'd11);
        step();
        chk("t3_pre_count", count, 2);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 64'(12 + k), 64'd0, SEL_ADD, RD_W'(12 + k));
            chk("t3_stream_rd", out_rd, 64'(10 + k));
            chk("t3_stream_count", count, 2);
            step();
        end
        drive(1'b0, 64'h0, 64'h0, '0, '0);
        out_ready = 1'b0;
        chk("t3_post_count", count, 2);
        chk("t3_post_rd", out_rd, 30);
        chk("t3_post_op1", out_op1, 64'd30);

        // Flush with concurrent enqueue and dequeue
        drive(1'b1, 64'd32, 64'd0, SEL_ADD, 5'd1);
        step();
        chk("t4_fill_count", count, 3);
        drive(1'b1, 64'hDEAD, 64'hBEEF, 6'h3F, 5'd31);
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("t4_count", count, 0);
        chk("t4_valid", out_valid, 0);
        chk("t4_op1", out_op1, 0);
        chk("t4_op2", out_op2, 0);
        chk("t4_sel", out_sel, 0);
        chk("t4_rd", out_rd, 0);
        chk("t4_in_ready", in_ready, 1);
        step();
        chk("t4_still_empty", out_valid, 0);

        // Asynchronous reset mid-operation
        drive(1'b1, 64'h1, 64'h2, SEL_ADD, 5'd3);
        step();
        drive(1'b1, 64'h4, 64'h5, SEL_ADD, 5'd6);
        step();
        in_valid = 1'b0;
        chk("t5_pre_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_count", count, 0);
        chk("t5_async_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        chk("t5_rel_in_ready", in_ready, 1);
        drive(1'b1, 64'h77, 64'h88, 6'h2A, 5'd7);
        step();
        in_valid = 1'b0;
        chk("t5_new_valid", out_valid, 1);
        chk("t5_new_op1", out_op1, 64'h77);
        chk("t5_new_op2", out_op2, 64'h88);
        chk("t5_new_sel", out_sel, 6'h2A);
        chk("t5_new_rd", out_rd, 7);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_drained", count, 0);

        // AUIPC op passes through unmodified, never bypassed
        drive(1'b1, 64'h8000_0000, 64'hABCDE, SEL_AUIPC, 5'd9);
        chk("t6_nobypass_valid", out_valid, 0);
        chk("t6_nobypass_op1", out_op1, 0);
        step();
        drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF, 6'h3F, 5'd31);
        chk("t6_valid", out_valid, 1);
        chk("t6_op1", out_op1, 64'h8000_0000);
        chk("t6_op2", out_op2, 64'hABCDE);
        chk("t6_sel", out_sel, SEL_AUIPC);
        chk("t6_rd", out_rd, 9);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_empty", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_issue_queue.md
Name: ex_issue_queue

Overview:
- Stage-3 issue queue directly upstream of the base integer execution unit (ADD/SUB/AUIPC/shift/logic ops, 64-bit op1/op2 plus op-select code).
- Buffers decoded ALU micro-ops from stage 2 in a small in-order FIFO.
- Presents the oldest entry to the EU with a valid/ready handshake.
- Supports pipeline flush on branch mispredict or trap.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- SEL_W, 6, width of the op-select code forwarded to the EU.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; discards all entries.
- in_valid  input  1  stage 2 presents a micro-op.
- in_ready  output  1  queue can accept a micro-op this cycle.
- in_op1  input  64  operand 1; carries the PC for AUIPC.
- in_op2  input  64  operand 2 or immediate; imm[19:0] for AUIPC.
- in_sel  input  SEL_W  op-select code, passed through unmodified.
- in_rd  input  RD_W  destination register index.
- out_valid  output  1  head entry valid toward the EU.
- out_ready  input  1  EU consumes the head this cycle.
- out_op1  output  64  head operand 1.
- out_op2  output  64  head operand 2.
- out_sel  output  SEL_W  head op-select.
- out_rd  output  RD_W  head destination index.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH entries of {op1, op2, sel, rd}; read pointer, write pointer, occupancy counter; pointers wrap modulo DEPTH.
- Reset (rst_n=0, asynchronous):
  - pointers and count go to 0; out_valid=0.
  - in_ready=1 while held in reset and on the first cycle after release.
  - Entry storage is not reset.
- in_ready = (count != DEPTH).
  - Depends only on state, never on out_ready; no combinational path from out_ready to in_ready.
  - When full, no enqueue occurs even if the EU dequeues that same cycle.
- out_valid = (count != 0).
- Show-ahead: out_* reflect the head entry combinationally from storage.
  - When out_valid=0, out_op1/out_op2/out_sel/out_rd are all driven to 0.
- Enqueue: occurs when in_valid && in_ready.
  - Writes the entry at wptr; wptr increments.
  - Data is visible at the head the next cycle at the earliest. There is no bypass from input to output (latency 1 cycle from accept to out_valid).
- Dequeue: occurs when out_valid && out_ready; rptr increments.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal at any count from 1 to DEPTH-1.
- Empty: a dequeue is impossible (out_valid=0); out_ready is ignored.
- Full: in_valid is ignored and stage 2 must hold its data.
- Upstream holds in_* stable while in_valid && !in_ready. The queue does not check this.
- EU holds nothing; out_* may change only after a dequeue or an enqueue into an empty queue.
- Flush (flush=1 at a clock edge):
  - Next state is count=0, rptr=wptr=0.
  - Any enqueue or dequeue in that same cycle is discarded; flush has priority over both.
  - in_ready stays as computed from current state during the flush cycle. Upstream must not count a flush-cycle handshake as accepted.
- Reset mid-operation: all in-flight entries are lost. out_valid falls asynchronously with rst_n assertion.
- Ordering: strictly FIFO; entries are never reordered, merged or modified.
- in_sel is not decoded; unknown codes pass through.

Test Plan:
- Reset, then enqueue one op {op1=64'h10, op2=64'h20, sel=ADD, rd=5} with out_ready=0 -> out_valid=1 on the next cycle with identical fields, count=1; assert out_ready -> out_valid=0, count=0 on the following cycle.
- Enqueue 4 ops (rd=1..4) with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is held for 3 cycles and not accepted; then out_ready=1 drains rd 1,2,3,4 in order, then the 5th.
- Steady streaming with in_valid=out_ready=1 for 20 cycles at count=2 -> count stays 2, pointers wrap 5 times, output rd sequence matches input order with exactly a 2-entry delay.
- Fill 3 entries, then assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_* all 0; the flushed-cycle input never appears at the output.
- Fill 2 entries, pulse rst_n low mid-cycle -> out_valid drops immediately and count=0; after release, in_ready=1 and the first new enqueue appears at the head with correct data.
- Enqueue an AUIPC op {op1=PC 64'h8000_0000, op2=20'hABCDE, sel=AUIPC} into an empty queue -> the head presents the same unmodified fields; out_* are never a pass-through of in_* in the enqueue cycle.
